// File: rtl/apb_arbiter_2to1.sv
// Two-requester APB arbiter: one downstream APB completer port is shared round-robin between two
// upstream APB requester ports, one full transfer per grant; the losing requester is stalled via pready.
module apb_arbiter_2to1 #(
    parameter int G_REGWIDTH   = 32,
    parameter int G_ADDR_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      s0_apb_psel,
    input  logic                      s0_apb_penable,
    input  logic                      s0_apb_pwrite,
    input  logic [2:0]                s0_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]   s0_apb_paddr,
    input  logic [G_REGWIDTH-1:0]     s0_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]   s0_apb_pstrb,
    output logic                      s0_apb_pready,
    output logic [G_REGWIDTH-1:0]     s0_apb_prdata,
    output logic                      s0_apb_pslverr,

    input  logic                      s1_apb_psel,
    input  logic                      s1_apb_penable,
    input  logic                      s1_apb_pwrite,
    input  logic [2:0]                s1_apb_pprot,
    input  logic [G_ADDR_WIDTH-1:0]   s1_apb_paddr,
    input  logic [G_REGWIDTH-1:0]     s1_apb_pwdata,
    input  logic [G_REGWIDTH/8-1:0]   s1_apb_pstrb,
    output logic                      s1_apb_pready,
    output logic [G_REGWIDTH-1:0]     s1_apb_prdata,
    output logic                      s1_apb_pslverr,

    output logic                      m_apb_psel,
    output logic                      m_apb_penable,
    output logic                      m_apb_pwrite,
    output logic [2:0]                m_apb_pprot,
    output logic [G_ADDR_WIDTH-1:0]   m_apb_paddr,
    output logic [G_REGWIDTH-1:0]     m_apb_pwdata,
    output logic [G_REGWIDTH/8-1:0]   m_apb_pstrb,
    input  logic                      m_apb_pready,
    input  logic [G_REGWIDTH-1:0]     m_apb_prdata,
    input  logic                      m_apb_pslverr,

    output logic                      grant_id
);

    // state     | meaning
    // ST_IDLE   | downstream idle; arbitrate between pending psel requests
    // ST_SETUP  | downstream SETUP phase for the granted requester
    // ST_ACCESS | downstream ACCESS phase; wait for m_apb_pready
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [1:0] state_q, state_d;
    logic       grant_q, grant_d;
    logic       last_grant_q, last_grant_d;

    logic       xfer_active;
    logic       in_access;
    logic       xfer_done;

    // Upstream penable plays no part in arbitration; the granted requester's phase is re-created downstream.
    logic       penable_unused;
    assign penable_unused = s0_apb_penable | s1_apb_penable;

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (s0_apb_psel || s1_apb_psel) begin
                    state_d = ST_SETUP;
                    if (s0_apb_psel && s1_apb_psel) begin
                        grant_d = ~last_grant_q;
                    end else begin
                        grant_d = s1_apb_psel;
                    end
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (m_apb_pready) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Port 0 wins the first tie after reset, hence last_grant resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign xfer_active = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign in_access   = (state_q == ST_ACCESS);
    assign xfer_done   = in_access && m_apb_pready;
    assign grant_id    = grant_q;

    always_comb begin
        m_apb_psel    = xfer_active;
        m_apb_penable = in_access;
        m_apb_pwrite  = 1'b0;
        m_apb_pprot   = '0;
        m_apb_paddr   = '0;
        m_apb_pwdata  = '0;
        m_apb_pstrb   = '0;
        if (xfer_active) begin
            if (grant_q) begin
                m_apb_pwrite = s1_apb_pwrite;
                m_apb_pprot  = s1_apb_pprot;
                m_apb_paddr  = s1_apb_paddr;
                m_apb_pwdata = s1_apb_pwdata;
                m_apb_pstrb  = s1_apb_pstrb;
            end else begin
                m_apb_pwrite = s0_apb_pwrite;
                m_apb_pprot  = s0_apb_pprot;
                m_apb_paddr  = s0_apb_paddr;
                m_apb_pwdata = s0_apb_pwdata;
                m_apb_pstrb  = s0_apb_pstrb;
            end
        end
    end

    // Response is steered only to the granted port and only on the completing cycle.
    always_comb begin
        s0_apb_pready  = 1'b0;
        s0_apb_prdata  = '0;
        s0_apb_pslverr = 1'b0;
        s1_apb_pready  = 1'b0;
        s1_apb_prdata  = '0;
        s1_apb_pslverr = 1'b0;
        if (xfer_done) begin
            if (grant_q) begin
                s1_apb_pready  = 1'b1;
                s1_apb_prdata  = m_apb_prdata;
                s1_apb_pslverr = m_apb_pslverr;
            end else begin
                s0_apb_pready  = 1'b1;
                s0_apb_prdata  = m_apb_prdata;
                s0_apb_pslverr = m_apb_pslverr;
            end
        end
    end

endmodule
